// File: rtl/tlb_ctrl_pkg.sv
// Shared definitions for the TLB maintenance sequencer: op encodings, FSM states and
// architectural constants.
package tlb_ctrl_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  // Highest defined INVTLB operation; anything above is illegal.
  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/tlb_ctrl_if.sv
// Request/response, CSR and TLB-port bundle of tlb_ctrl. The master modport is the
// sequencer side; slave is the execute/commit/TLB-array side.
interface tlb_ctrl_if #(
  parameter int unsigned IDXW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [4:0]      req_inv_op;
  logic [9:0]      req_inv_asid;
  logic [18:0]     req_inv_vppn;

  logic [IDXW-1:0] csr_idx;
  logic [5:0]      csr_ps;
  logic            csr_ne;
  logic [18:0]     csr_vppn;
  logic [9:0]      csr_asid;
  logic [27:0]     csr_elo0;
  logic [27:0]     csr_elo1;
  logic            csr_refill;

  logic            srch_en;
  logic [19:0]     srch_vpn;
  logic [9:0]      srch_asid;
  logic            srch_hit;
  logic [IDXW-1:0] srch_idx;

  logic [IDXW-1:0] r_idx;
  logic [18:0]     r_vppn;
  logic [9:0]      r_asid;
  logic [5:0]      r_ps;
  logic            r_e;
  logic [27:0]     r_elo0;
  logic [27:0]     r_elo1;

  logic            w_en;
  logic [IDXW-1:0] w_idx;
  logic [18:0]     w_vppn;
  logic [5:0]      w_ps;
  logic [9:0]      w_asid;
  logic            w_e;
  logic [27:0]     w_tlbelo0;
  logic [27:0]     w_tlbelo1;

  logic            inv_en;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vppn;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_idx_we;
  logic            resp_ehi_we;
  logic            resp_elo_we;
  logic            resp_asid_we;
  logic [IDXW-1:0] resp_idx;
  logic            resp_ne;
  logic [5:0]      resp_ps;
  logic [18:0]     resp_vppn;
  logic [9:0]      resp_asid;
  logic [27:0]     resp_elo0;
  logic [27:0]     resp_elo1;
  logic            resp_ill;

  modport master (
    input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
    input  csr_idx, csr_ps, csr_ne, csr_vppn, csr_asid, csr_elo0, csr_elo1, csr_refill,
    input  srch_hit, srch_idx,
    input  r_vppn, r_asid, r_ps, r_e, r_elo0, r_elo1,
    input  resp_ready,
    output req_ready,
    output srch_en, srch_vpn, srch_asid,
    output r_idx,
    output w_en, w_idx, w_vppn, w_ps, w_asid, w_e, w_tlbelo0, w_tlbelo1,
    output inv_en, inv_op, inv_asid, inv_vppn,
    output resp_valid, resp_idx_we, resp_ehi_we, resp_elo_we, resp_asid_we,
    output resp_idx, resp_ne, resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1,
    output resp_ill
  );

  modport slave (
    output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
    output csr_idx, csr_ps, csr_ne, csr_vppn, csr_asid, csr_elo0, csr_elo1, csr_refill,
    output srch_hit, srch_idx,
    output r_vppn, r_asid, r_ps, r_e, r_elo0, r_elo1,
    output resp_ready,
    input  req_ready,
    input  srch_en, srch_vpn, srch_asid,
    input  r_idx,
    input  w_en, w_idx, w_vppn, w_ps, w_asid, w_e, w_tlbelo0, w_tlbelo1,
    input  inv_en, inv_op, inv_asid, inv_vppn,
    input  resp_valid, resp_idx_we, resp_ehi_we, resp_elo_we, resp_asid_we,
    input  resp_idx, resp_ne, resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1,
    input  resp_ill
  );

endinterface

// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: serialises SRCH/RD/WR/FILL/INV and returns one CSR update.
// Define TLB_SYNC_SRCH_EN for a registered-output TLB (search result sampled in WAIT).
module tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int unsigned IDXW = 4
) (
  input logic        clock,
  input logic        reset,
  tlb_ctrl_if.master bus
);

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vppn;
  logic [IDXW-1:0] r_csr_idx;
  logic [5:0]      r_csr_ps;
  logic            r_csr_ne;
  logic [18:0]     r_csr_vppn;
  logic [9:0]      r_csr_asid;
  logic [27:0]     r_csr_elo0;
  logic [27:0]     r_csr_elo1;
  logic            r_csr_refill;
  logic [IDXW-1:0] r_fill_cnt;

  logic            r_idx_we, r_ehi_we, r_elo_we, r_asid_we, r_ne, r_ill;
  logic [IDXW-1:0] r_resp_idx;
  logic [5:0]      r_ps;
  logic [18:0]     r_vppn;
  logic [9:0]      r_asid;
  logic [27:0]     r_elo0, r_elo1;

  logic            w_accept, w_exec, w_capture, w_inv_ill;
  logic            w_idx_we, w_ehi_we, w_elo_we, w_asid_we, w_ne, w_ill;
  logic [IDXW-1:0] w_res_idx;
  logic [5:0]      w_ps;
  logic [18:0]     w_vppn;
  logic [9:0]      w_asid;
  logic [27:0]     w_elo0, w_elo1;

  assign w_accept  = (r_state == StIdle) && bus.req_valid;
  // Reset is sampled synchronously but also masks EXEC pulses in its own cycle.
  assign w_exec    = (r_state == StExec) && reset;
  assign w_inv_ill = (r_inv_op > INV_OP_MAX);

`ifdef TLB_SYNC_SRCH_EN
  assign w_capture = ((r_state == StExec) && (r_op != TLBOP_SRCH)) || (r_state == StWait);
`else
  assign w_capture = (r_state == StExec);
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (bus.req_valid) w_state_nxt = StExec;
`ifdef TLB_SYNC_SRCH_EN
      StExec: w_state_nxt = (r_op == TLBOP_SRCH) ? StWait : StResp;
`else
      StExec: w_state_nxt = StResp;
`endif
      StWait: w_state_nxt = StResp;
      StResp: if (bus.resp_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Response contents, computed from the live TLB result and captured when valid.
  always_comb begin
    w_res_idx = r_csr_idx;
    w_ne      = 1'b0;
    w_ps      = '0;
    w_vppn    = '0;
    w_asid    = '0;
    w_elo0    = '0;
    w_elo1    = '0;
    w_idx_we  = 1'b0;
    w_ehi_we  = 1'b0;
    w_elo_we  = 1'b0;
    w_asid_we = 1'b0;
    w_ill     = 1'b0;
    case (r_op)
      TLBOP_SRCH: begin
        w_idx_we = 1'b1;
        if (bus.srch_hit) w_res_idx = bus.srch_idx;
        else              w_ne      = 1'b1;
      end
      TLBOP_RD: begin
        w_idx_we  = 1'b1;
        w_ehi_we  = 1'b1;
        w_elo_we  = 1'b1;
        w_asid_we = 1'b1;
        if (bus.r_e) begin
          w_ps   = bus.r_ps;
          w_vppn = bus.r_vppn;
          w_asid = bus.r_asid;
          w_elo0 = bus.r_elo0;
          w_elo1 = bus.r_elo1;
        end else begin
          w_ne = 1'b1;
        end
      end
      TLBOP_WR, TLBOP_FILL: ;
      TLBOP_INV: w_ill = w_inv_ill;
      default:   w_ill = 1'b1;
    endcase
  end

  always_comb begin
    bus.srch_en   = 1'b0;
    bus.srch_vpn  = '0;
    bus.srch_asid = '0;
    bus.r_idx     = '0;
    bus.w_en      = 1'b0;
    bus.w_idx     = '0;
    bus.w_vppn    = '0;
    bus.w_ps      = '0;
    bus.w_asid    = '0;
    bus.w_e       = 1'b0;
    bus.w_tlbelo0 = '0;
    bus.w_tlbelo1 = '0;
    bus.inv_en    = 1'b0;
    bus.inv_op    = '0;
    bus.inv_asid  = '0;
    bus.inv_vppn  = '0;
    if (w_exec) begin
      case (r_op)
        TLBOP_SRCH: begin
          bus.srch_en   = 1'b1;
          bus.srch_vpn  = {r_csr_vppn, 1'b0};
          bus.srch_asid = r_csr_asid;
        end
        TLBOP_RD: bus.r_idx = r_csr_idx;
        TLBOP_WR, TLBOP_FILL: begin
          bus.w_en      = 1'b1;
          bus.w_idx     = (r_op == TLBOP_FILL) ? r_fill_cnt : r_csr_idx;
          bus.w_vppn    = r_csr_vppn;
          bus.w_ps      = r_csr_ps;
          bus.w_asid    = r_csr_asid;
          bus.w_e       = r_csr_refill | ~r_csr_ne;
          bus.w_tlbelo0 = r_csr_elo0;
          bus.w_tlbelo1 = r_csr_elo1;
        end
        TLBOP_INV: begin
          if (!w_inv_ill) begin
            bus.inv_en   = 1'b1;
            bus.inv_op   = r_inv_op;
            bus.inv_asid = r_inv_asid;
            bus.inv_vppn = r_inv_vppn;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_fill_cnt   <= '0;
      r_op         <= '0;
      r_inv_op     <= '0;
      r_inv_asid   <= '0;
      r_inv_vppn   <= '0;
      r_csr_idx    <= '0;
      r_csr_ps     <= '0;
      r_csr_ne     <= 1'b0;
      r_csr_vppn   <= '0;
      r_csr_asid   <= '0;
      r_csr_elo0   <= '0;
      r_csr_elo1   <= '0;
      r_csr_refill <= 1'b0;
      r_idx_we     <= 1'b0;
      r_ehi_we     <= 1'b0;
      r_elo_we     <= 1'b0;
      r_asid_we    <= 1'b0;
      r_ne         <= 1'b0;
      r_ill        <= 1'b0;
      r_resp_idx   <= '0;
      r_ps         <= '0;
      r_vppn       <= '0;
      r_asid       <= '0;
      r_elo0       <= '0;
      r_elo1       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= r_fill_cnt + 1'b1;
      if (w_accept) begin
        r_op         <= bus.req_op;
        r_inv_op     <= bus.req_inv_op;
        r_inv_asid   <= bus.req_inv_asid;
        r_inv_vppn   <= bus.req_inv_vppn;
        r_csr_idx    <= bus.csr_idx;
        r_csr_ps     <= bus.csr_ps;
        r_csr_ne     <= bus.csr_ne;
        r_csr_vppn   <= bus.csr_vppn;
        r_csr_asid   <= bus.csr_asid;
        r_csr_elo0   <= bus.csr_elo0;
        r_csr_elo1   <= bus.csr_elo1;
        r_csr_refill <= bus.csr_refill;
      end
      if (w_capture) begin
        r_idx_we   <= w_idx_we;
        r_ehi_we   <= w_ehi_we;
        r_elo_we   <= w_elo_we;
        r_asid_we  <= w_asid_we;
        r_ne       <= w_ne;
        r_ill      <= w_ill;
        r_resp_idx <= w_res_idx;
        r_ps       <= w_ps;
        r_vppn     <= w_vppn;
        r_asid     <= w_asid;
        r_elo0     <= w_elo0;
        r_elo1     <= w_elo1;
      end
    end
  end

  assign bus.req_ready    = (r_state == StIdle);
  assign bus.resp_valid   = (r_state == StResp);
  assign bus.resp_idx_we  = r_idx_we;
  assign bus.resp_ehi_we  = r_ehi_we;
  assign bus.resp_elo_we  = r_elo_we;
  assign bus.resp_asid_we = r_asid_we;
  assign bus.resp_idx     = r_resp_idx;
  assign bus.resp_ne      = r_ne;
  assign bus.resp_ps      = r_ps;
  assign bus.resp_vppn    = r_vppn;
  assign bus.resp_asid    = r_asid;
  assign bus.resp_elo0    = r_elo0;
  assign bus.resp_elo1    = r_elo1;
  assign bus.resp_ill     = r_ill;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl; honours TLB_SYNC_SRCH_EN for the search latency.
module tb_tlb_ctrl;
  import tlb_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errs   = 0;
  int   checks = 0;
  int   edges  = 0;

  always #5 clock = ~clock;

  tlb_ctrl_if #(.IDXW(4)) bus ();

  tlb_ctrl #(.IDXW(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; edges counts edges since reset was released.
  task automatic tick();
    @(posedge clock);
    if (reset) edges++;
    else       edges = 0;
    #1;
  endtask

  task automatic accept(input logic [2:0] op);
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic complete();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_inv_op = 0; bus.req_inv_asid = 0;
    bus.req_inv_vppn = 0; bus.csr_idx = 0; bus.csr_ps = 0; bus.csr_ne = 0;
    bus.csr_vppn = 0; bus.csr_asid = 0; bus.csr_elo0 = 0; bus.csr_elo1 = 0;
    bus.csr_refill = 0; bus.srch_hit = 0; bus.srch_idx = 0; bus.r_vppn = 0;
    bus.r_asid = 0; bus.r_ps = 0; bus.r_e = 0; bus.r_elo0 = 0; bus.r_elo1 = 0;
    bus.resp_ready = 0;

    reset = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_w_en", bus.w_en, 0);
    chk("rst_resp_ill", bus.resp_ill, 0);
    chk("rst_resp_idx", bus.resp_idx, 0);
    reset = 1'b1;

    // FILL right after reset: EXEC lands on the first counted edge.
    bus.csr_ne = 1'b0; bus.csr_idx = 4'd9; bus.csr_ps = PS_4K;
    accept(TLBOP_FILL);
    chk("fill0_w_en", bus.w_en, 1);
    chk("fill0_w_idx", bus.w_idx, 1);
    chk("fill0_w_e", bus.w_e, 1);
    tick();
    chk("fill0_w_en_pulse", bus.w_en, 0);
    chk("fill0_resp_valid", bus.resp_valid, 1);
    chk("fill0_idx_we", bus.resp_idx_we, 0);
    complete();
    chk("fill0_back_idle", bus.req_ready, 1);

    while (edges < 16) tick();
    accept(TLBOP_FILL);
    chk("fill17_w_idx", bus.w_idx, 1);
    tick();
    complete();

    // SRCH hit
    bus.csr_vppn = 19'h12345; bus.csr_asid = 10'h2A; bus.csr_idx = 4'd2;
    bus.srch_hit = 1'b1; bus.srch_idx = 4'd7;
    accept(TLBOP_SRCH);
    chk("srch_en", bus.srch_en, 1);
    chk("srch_vpn", bus.srch_vpn, 20'h2468A);
    chk("srch_asid", bus.srch_asid, 10'h2A);
    chk("srch_lat1", bus.resp_valid, 0);
    tick();
    chk("srch_en_pulse", bus.srch_en, 0);
`ifdef TLB_SYNC_SRCH_EN
    chk("srch_lat2", bus.resp_valid, 0);
    tick();
`endif
    chk("srch_resp_valid", bus.resp_valid, 1);
    chk("srch_hit_idx", bus.resp_idx, 7);
    chk("srch_hit_ne", bus.resp_ne, 0);
    chk("srch_idx_we", bus.resp_idx_we, 1);
    chk("srch_ehi_we", bus.resp_ehi_we, 0);
    complete();

    // SRCH miss
    bus.srch_hit = 1'b0; bus.csr_idx = 4'd5;
    accept(TLBOP_SRCH);
    tick();
`ifdef TLB_SYNC_SRCH_EN
    tick();
`endif
    chk("srch_miss_ne", bus.resp_ne, 1);
    chk("srch_miss_idx", bus.resp_idx, 5);
    complete();

    // RD valid entry
    bus.csr_idx = 4'd3; bus.r_e = 1'b1; bus.r_ps = PS_2M; bus.r_vppn = 19'h5A5A5;
    bus.r_asid = 10'h155; bus.r_elo0 = 28'hABCDEF1; bus.r_elo1 = 28'h1234567;
    accept(TLBOP_RD);
    chk("rd_r_idx", bus.r_idx, 3);
    tick();
    chk("rd_resp_valid", bus.resp_valid, 1);
    chk("rd_ne", bus.resp_ne, 0);
    chk("rd_ps", bus.resp_ps, 21);
    chk("rd_vppn", bus.resp_vppn, 19'h5A5A5);
    chk("rd_asid", bus.resp_asid, 10'h155);
    chk("rd_elo0", bus.resp_elo0, 28'hABCDEF1);
    chk("rd_elo1", bus.resp_elo1, 28'h1234567);
    chk("rd_we", {bus.resp_idx_we, bus.resp_ehi_we, bus.resp_elo_we, bus.resp_asid_we}, 4'hF);

    // Stall the response while a WR waits upstream; it must not be taken early.
    bus.req_op = TLBOP_WR; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", bus.resp_valid, 1);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_elo1", bus.resp_elo1, 28'h1234567);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("hs_no_accept_w_en", bus.w_en, 0);
    chk("hs_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b0;

    // RD invalid entry
    bus.r_e = 1'b0;
    accept(TLBOP_RD);
    tick();
    chk("rd0_ne", bus.resp_ne, 1);
    chk("rd0_data", {bus.resp_ps, bus.resp_vppn, bus.resp_asid}, 0);
    chk("rd0_elo", {bus.resp_elo0, bus.resp_elo1}, 0);
    complete();

    // WR with NE set, then with refill
    bus.csr_idx = 4'd9; bus.csr_ne = 1'b1; bus.csr_refill = 1'b0; bus.csr_ps = PS_4K;
    bus.csr_vppn = 19'h0ABCD; bus.csr_elo0 = 28'h0000F0F;
    accept(TLBOP_WR);
    chk("wr_w_en", bus.w_en, 1);
    chk("wr_w_idx", bus.w_idx, 9);
    chk("wr_w_e", bus.w_e, 0);
    chk("wr_w_ps", bus.w_ps, 12);
    chk("wr_w_vppn", bus.w_vppn, 19'h0ABCD);
    chk("wr_w_elo0", bus.w_tlbelo0, 28'h0000F0F);
    tick();
    chk("wr_no_we", bus.resp_idx_we | bus.resp_ehi_we | bus.resp_elo_we | bus.resp_asid_we, 0);
    complete();
    bus.csr_refill = 1'b1;
    accept(TLBOP_WR);
    chk("wr_refill_w_e", bus.w_e, 1);
    tick();
    complete();

    // INVTLB legal and illegal
    bus.req_inv_op = 5'd5; bus.req_inv_asid = 10'h2A; bus.req_inv_vppn = 19'h3C3C3;
    accept(TLBOP_INV);
    chk("inv_en", bus.inv_en, 1);
    chk("inv_op", bus.inv_op, 5);
    chk("inv_asid", bus.inv_asid, 10'h2A);
    chk("inv_vppn", bus.inv_vppn, 19'h3C3C3);
    tick();
    chk("inv_en_pulse", bus.inv_en, 0);
    chk("inv_ill", bus.resp_ill, 0);
    complete();
    bus.req_inv_op = 5'd7;
    accept(TLBOP_INV);
    chk("inv7_no_en", bus.inv_en, 0);
    tick();
    chk("inv7_ill", bus.resp_ill, 1);
    complete();

    // Illegal op
    bus.req_inv_op = 5'd0;
    accept(3'd6);
    chk("illop_ports", {bus.srch_en, bus.w_en, bus.inv_en}, 0);
    tick();
    chk("illop_ill", bus.resp_ill, 1);
    complete();

    // Reset asserted during EXEC of a WR
    accept(TLBOP_WR);
    reset = 1'b0;
    #1;
    chk("rst_exec_w_en", bus.w_en, 0);
    tick();
    reset = 1'b1;
    chk("rst_exec_idle", bus.req_ready, 1);
    chk("rst_exec_no_resp", bus.resp_valid, 0);
    tick();
    chk("rst_exec_stays_idle", bus.w_en, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
